// File: rtl/io_arbiter_if.sv
// io_arbiter_if: bundles the two requester ports and the dual byte-lane IO
// port of io_arbiter.
//   slave  modport - arbiter side: takes requests and lane read bytes; drives
//                    grants, read returns, lane addresses, lane data, strobes.
//   master modport - requester/IO side: the mirror image.
// Signal names match the legacy flat port names.
interface io_arbiter_if;
  logic        r0_req,    r1_req;
  logic        r0_we,     r1_we;
  logic        r0_wide,   r1_wide;
  logic        r0_lock,   r1_lock;
  logic [15:0] r0_addr,   r1_addr;
  logic [15:0] r0_wdata,  r1_wdata;
  logic        r0_gnt,    r1_gnt;
  logic        r0_rvalid, r1_rvalid;
  logic [15:0] r0_rdata,  r1_rdata;
  logic [14:0] read_addr_even,  read_addr_odd;
  logic [14:0] write_addr_even, write_addr_odd;
  logic [7:0]  write_data_even, write_data_odd;
  logic        write_en_even,   write_en_odd;
  logic [7:0]  read_data_even,  read_data_odd;

  modport slave (
    input  r0_req, r1_req, r0_we, r1_we, r0_wide, r1_wide, r0_lock, r1_lock,
           r0_addr, r1_addr, r0_wdata, r1_wdata, read_data_even, read_data_odd,
    output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
           read_addr_even, read_addr_odd, write_addr_even, write_addr_odd,
           write_data_even, write_data_odd, write_en_even, write_en_odd
  );

  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_wide, r1_wide, r0_lock, r1_lock,
           r0_addr, r1_addr, r0_wdata, r1_wdata, read_data_even, read_data_odd,
    input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
           read_addr_even, read_addr_odd, write_addr_even, write_addr_odd,
           write_data_even, write_data_odd, write_en_even, write_en_odd
  );
endinterface

// File: rtl/io_arbiter.sv
// io_arbiter: two-requester, zero-latency round-robin arbiter with bounded
// lock, mapping byte/16-bit accesses onto an even/odd byte-lane IO system.
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - io_arbiter_if.slave (requests, grants, read returns, lane IO)
// Parameter LOCK_MAX (1..255): max consecutive locked grants to one owner.
module io_arbiter #(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic         clk,
  input  logic         reset,
  io_arbiter_if.slave  bus
);

  localparam logic [7:0] LP_LOCK_MAX = 8'(LOCK_MAX);

  logic        r_prio1;      // 1: r1 wins a tie
  logic        r_locked;     // previous grant carried lock
  logic        r_owner;      // requester of the previous grant
  logic [7:0]  r_lock_cnt;
  logic [14:0] r_addr_even, r_addr_odd;
  logic [7:0]  r_wdata_even, r_wdata_odd;
  logic        r_rd_v, r_rd_id, r_rd_wide, r_rd_odd;

  logic        w_gnt0, w_gnt1, w_gnt, w_sel;
  logic        w_own_lock, w_own_req, w_hold;
  logic        w_we, w_wide, w_lock;
  logic [15:0] w_addr, w_wdata;
  logic [14:0] w_a, w_a1;
  logic        w_use_even, w_use_odd;
  logic [14:0] w_cand_addr_even, w_cand_addr_odd;
  logic [7:0]  w_cand_data_even, w_cand_data_odd;
  logic [14:0] w_addr_even, w_addr_odd;
  logic [7:0]  w_wdata_even, w_wdata_odd;
  logic [15:0] w_rdata;

  assign w_own_lock = r_owner ? bus.r1_lock : bus.r0_lock;
  assign w_own_req  = r_owner ? bus.r1_req  : bus.r0_req;
  assign w_hold     = r_locked && w_own_lock && w_own_req && (r_lock_cnt < LP_LOCK_MAX);

  // Grants are combinational from req; gated by reset so they drop at once.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      if (w_hold) begin
        w_gnt0 = !r_owner;
        w_gnt1 = r_owner;
      end else if (bus.r0_req && bus.r1_req) begin
        w_gnt0 = !r_prio1;
        w_gnt1 = r_prio1;
      end else begin
        w_gnt0 = bus.r0_req;
        w_gnt1 = bus.r1_req;
      end
    end
  end

  assign w_gnt   = w_gnt0 | w_gnt1;
  assign w_sel   = w_gnt1;
  assign w_we    = w_sel ? bus.r1_we    : bus.r0_we;
  assign w_wide  = w_sel ? bus.r1_wide  : bus.r0_wide;
  assign w_lock  = w_sel ? bus.r1_lock  : bus.r0_lock;
  assign w_addr  = w_sel ? bus.r1_addr  : bus.r0_addr;
  assign w_wdata = w_sel ? bus.r1_wdata : bus.r0_wdata;
  assign w_a     = w_addr[15:1];
  assign w_a1    = w_a + 15'd1;   // natural 15-bit wrap

  always_comb begin
    w_use_even       = 1'b0;
    w_use_odd        = 1'b0;
    w_cand_addr_even = w_a;
    w_cand_addr_odd  = w_a;
    w_cand_data_even = w_wdata[7:0];
    w_cand_data_odd  = w_wdata[7:0];
    case ({w_wide, w_addr[0]})
      2'b00: w_use_even = 1'b1;
      2'b01: w_use_odd  = 1'b1;
      2'b10: begin
        w_use_even      = 1'b1;
        w_use_odd       = 1'b1;
        w_cand_data_odd = w_wdata[15:8];
      end
      default: begin
        // unaligned wide: low byte on odd lane, high byte on next even word
        w_use_even       = 1'b1;
        w_use_odd        = 1'b1;
        w_cand_addr_even = w_a1;
        w_cand_data_even = w_wdata[15:8];
      end
    endcase
  end

  // Lane outputs follow the grant in the same cycle and otherwise show the
  // registered copy, which is what gives "hold last value" between grants.
  assign w_addr_even  = (w_gnt && w_use_even)         ? w_cand_addr_even : r_addr_even;
  assign w_addr_odd   = (w_gnt && w_use_odd)          ? w_cand_addr_odd  : r_addr_odd;
  assign w_wdata_even = (w_gnt && w_we && w_use_even) ? w_cand_data_even : r_wdata_even;
  assign w_wdata_odd  = (w_gnt && w_we && w_use_odd)  ? w_cand_data_odd  : r_wdata_odd;

  assign bus.r0_gnt          = w_gnt0;
  assign bus.r1_gnt          = w_gnt1;
  assign bus.read_addr_even  = w_addr_even;
  assign bus.read_addr_odd   = w_addr_odd;
  assign bus.write_addr_even = w_addr_even;
  assign bus.write_addr_odd  = w_addr_odd;
  assign bus.write_data_even = w_wdata_even;
  assign bus.write_data_odd  = w_wdata_odd;
  assign bus.write_en_even   = w_gnt && w_we && w_use_even;
  assign bus.write_en_odd    = w_gnt && w_we && w_use_odd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio1      <= 1'b0;
      r_locked     <= 1'b0;
      r_owner      <= 1'b0;
      r_lock_cnt   <= '0;
      r_addr_even  <= '0;
      r_addr_odd   <= '0;
      r_wdata_even <= '0;
      r_wdata_odd  <= '0;
      r_rd_v       <= 1'b0;
      r_rd_id      <= 1'b0;
      r_rd_wide    <= 1'b0;
      r_rd_odd     <= 1'b0;
    end else begin
      r_addr_even  <= w_addr_even;
      r_addr_odd   <= w_addr_odd;
      r_wdata_even <= w_wdata_even;
      r_wdata_odd  <= w_wdata_odd;
      r_rd_v       <= w_gnt && !w_we;
      r_rd_id      <= w_sel;
      r_rd_wide    <= w_wide;
      r_rd_odd     <= w_addr[0];
      if (w_gnt) begin
        r_prio1 <= w_gnt0;
        r_owner <= w_sel;
        if (w_lock) begin
          r_locked   <= 1'b1;
          // a fresh lock (new owner or expired window) starts counting at 1
          r_lock_cnt <= (r_locked && (r_owner == w_sel) && (r_lock_cnt < LP_LOCK_MAX))
                        ? r_lock_cnt + 8'd1 : 8'd1;
        end else begin
          r_locked   <= 1'b0;
          r_lock_cnt <= '0;
        end
      end else if (r_locked && !w_own_lock) begin
        r_locked   <= 1'b0;
        r_lock_cnt <= '0;
      end
    end
  end

  always_comb begin
    case ({r_rd_wide, r_rd_odd})
      2'b00:   w_rdata = {8'h00, bus.read_data_even};
      2'b01:   w_rdata = {8'h00, bus.read_data_odd};
      2'b10:   w_rdata = {bus.read_data_odd, bus.read_data_even};
      default: w_rdata = {bus.read_data_even, bus.read_data_odd};
    endcase
  end

  assign bus.r0_rvalid = r_rd_v && !r_rd_id;
  assign bus.r1_rvalid = r_rd_v &&  r_rd_id;
  assign bus.r0_rdata  = bus.r0_rvalid ? w_rdata : '0;
  assign bus.r1_rdata  = bus.r1_rvalid ? w_rdata : '0;

endmodule
